sent_tx_pulse_gen: RTL and testbench
====================================

SENT_TX_PULSE_GEN -- requirements
Module: sent_tx_pulse_gen

Interface
REQ-001 SHALL have parameter CLK_PER_TICK, default 3, meaning clk cycles per SENT unit tick (legal 1..255).
REQ-002 SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port frame_valid  input  1  frame request from the control block.
REQ-005 SHALL have port frame_ready  output  1  block can accept a frame.
REQ-006 SHALL have port status_nibble  input  4  status/communication nibble.
REQ-007 SHALL have port data_nibbles  input  24  data nibbles, right-aligned (same alignment as the CRC generator's data_to_crc).
REQ-008 SHALL have port num_nibbles  input  3  data nibble count, legal 1..6.
REQ-009 SHALL have port crc_nibble  input  4  crc_fast from the CRC generator.
REQ-010 SHALL have port pause_en  input  1  append a pause pulse.
REQ-011 SHALL have port pause_ticks  input  10  pause pulse length in ticks.
REQ-012 SHALL have port sent_out  output  1  SENT line; idle high.
REQ-013 SHALL have port busy  output  1  frame in progress.
REQ-014 SHALL have port frame_done  output  1  one-cycle end-of-frame strobe.

Function
REQ-015 SHALL implement the FSM IDLE -> SYNC -> STATUS -> DATA -> CRC -> (PAUSE if pause_en) -> IDLE.
REQ-016 SHALL drive frame_ready = 1 only in IDLE, and busy = not IDLE.
REQ-017 SHALL, on a clk edge with frame_valid and frame_ready, latch all frame inputs, enter SYNC, and restart the prescaler; later input changes SHALL have no effect on the frame.
REQ-018 SHALL drive sent_out low starting in the cycle after acceptance (latency 1 clk).
REQ-019 SHALL generate a tick strobe once every CLK_PER_TICK clks, counted from acceptance.
REQ-020 SHALL build every pulse as 4 ticks low followed by high for the rest of its length.
REQ-021 SHALL use these pulse lengths: SYNC 56 ticks; STATUS, DATA and CRC 12+nibble value ticks; PAUSE = pause_ticks.
REQ-022 SHALL clamp pause_ticks values below 12 to 12.
REQ-023 SHALL send the N data nibbles MSB-first from data_nibbles[4N-1:0], where N = num_nibbles.
REQ-024 SHALL treat num_nibbles values 0 and 7 as 6.
REQ-025 SHALL keep the nibble index internal to DATA and move to CRC after nibble N-1.
REQ-026 SHALL, on the final tick of the last pulse, assert frame_done for one clk, return to IDLE on the same edge, and drive sent_out high.
REQ-027 SHALL assert frame_ready in the same cycle as frame_done, so a held frame_valid is accepted on the next edge with a 1-clk high gap.
REQ-028 SHALL ignore frame_valid while busy, with no queueing.
REQ-029 SHALL size the per-pulse tick counter at 10 bits; the maximum pulse is 1023 ticks with no wrap.

Reset
REQ-030 SHALL, while reset is high, force state IDLE, sent_out = 1, frame_ready = 1, busy = 0, frame_done = 0, and clear all counters and latched frame registers.
REQ-031 SHALL, on reset mid-frame, abort the frame without asserting frame_done and raise sent_out immediately.

Structure
REQ-032 SHALL place SYNC_TICKS = 56, NIBBLE_BASE_TICKS = 12, LOW_TICKS = 4, PAUSE_MIN_TICKS = 12 and the FSM state encoding in a shared package sent_pkg.
REQ-033 SHALL implement the tick prescaler as sub-module sent_tick_prescaler (inputs clk, reset, restart; output tick).

Verification
REQ-034 SHALL cover: CLK_PER_TICK=1, status 0x0, num_nibbles=3, data 0x2C7, crc 0xD, pause_en=0 -> pulse lengths 56,12,14,24,19,25 ticks, each 4 low; total 150 clks; frame_done once.
REQ-035 SHALL cover: CLK_PER_TICK=3, same frame -> sync low for 12 clks, frame lasting 450 clks, sent_out low 1 clk after acceptance.
REQ-036 SHALL cover: num_nibbles=6, data 0xFFFFFF, crc 0x0 -> six 27-tick data pulses; and num_nibbles=0 -> identical waveform.
REQ-037 SHALL cover: pause_en=1 with pause_ticks=5 -> 12-tick pause; with pause_ticks=300 -> 300-tick pause.
REQ-038 SHALL cover: frame_valid held high with inputs changed mid-frame -> first frame unchanged, second frame starts after a 1-clk high gap.
REQ-039 SHALL cover: reset asserted during the second data nibble -> sent_out high asynchronously, no frame_done, and the next frame is normal.

Source files
------------

// File: rtl/sent_pkg.sv
// sent_pkg: shared SENT timing constants, FSM state encoding and pulse-length helper.
// No ports; imported by sent_tick_prescaler and sent_tx_pulse_gen.
package sent_pkg;
   localparam int unsigned SYNC_TICKS        = 56;
   localparam int unsigned NIBBLE_BASE_TICKS = 12;
   localparam int unsigned LOW_TICKS         = 4;
   localparam int unsigned PAUSE_MIN_TICKS   = 12;
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_STATUS,
      ST_DATA,
      ST_CRC,
      ST_PAUSE
   } state_e;
   function automatic logic [9:0] nib_len(input logic [3:0] n);
      return 10'(NIBBLE_BASE_TICKS) + {6'd0, n};
   endfunction
endpackage

// File: rtl/sent_tick_prescaler.sv
// sent_tick_prescaler: emits a one-clk tick every CLK_PER_TICK clks, phase set by restart.
// Ports: clk, reset (async, active high), restart (zero the phase), tick (strobe out).
module sent_tick_prescaler #(
   parameter int unsigned CLK_PER_TICK = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   output logic tick
);
   localparam logic [7:0] LAST = 8'(CLK_PER_TICK - 1);
   logic [7:0] cnt_q, cnt_d;
   assign tick = cnt_q == LAST;
   always_comb cnt_d = (restart || tick) ? 8'd0 : cnt_q + 8'd1;
   always_ff @(posedge clk or posedge reset)
      if (reset) cnt_q <= 8'd0;
      else       cnt_q <= cnt_d;
endmodule

// File: rtl/sent_tx_pulse_gen.sv
// sent_tx_pulse_gen: SENT transmit pulse generator (sync, status, data, crc, optional pause).
// Ports: clk, reset (async, active high); frame_valid/frame_ready handshake; frame inputs
// status_nibble, data_nibbles (right-aligned), num_nibbles, crc_nibble, pause_en, pause_ticks;
// outputs sent_out (idle high), busy, frame_done (one-clk end-of-frame strobe).
module sent_tx_pulse_gen
   import sent_pkg::*;
#(
   parameter int unsigned CLK_PER_TICK = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frame_valid,
   output logic        frame_ready,
   input  logic [3:0]  status_nibble,
   input  logic [23:0] data_nibbles,
   input  logic [2:0]  num_nibbles,
   input  logic [3:0]  crc_nibble,
   input  logic        pause_en,
   input  logic [9:0]  pause_ticks,
   output logic        sent_out,
   output logic        busy,
   output logic        frame_done
);
   state_e      state_q, state_d;
   logic [9:0]  cnt_q, cnt_d, pause_q, pause_d, cur_len;
   logic [2:0]  idx_q, idx_d, n_q, n_d, n_eff;
   logic [3:0]  status_q, status_d, crc_q, crc_d;
   logic [23:0] data_q, data_d;
   logic        pause_en_q, pause_en_d, sent_out_q, sent_out_d, frame_done_q, frame_done_d;
   logic        tick, accept, pulse_end;

   sent_tick_prescaler #(.CLK_PER_TICK(CLK_PER_TICK)) u_presc (
      .clk     (clk),
      .reset   (reset),
      .restart (accept),
      .tick    (tick)
   );

   assign frame_ready = state_q == ST_IDLE;
   assign busy        = !frame_ready;
   assign sent_out    = sent_out_q;
   assign frame_done  = frame_done_q;
   assign accept      = frame_valid && frame_ready;
   assign n_eff       = (num_nibbles == 3'd0 || num_nibbles == 3'd7) ? 3'd6 : num_nibbles;

   always_comb begin
      cur_len = state_q == ST_SYNC   ? 10'(SYNC_TICKS) :
                state_q == ST_STATUS ? nib_len(status_q) :
                state_q == ST_DATA   ? nib_len(data_q[23:20]) :
                state_q == ST_CRC    ? nib_len(crc_q) : pause_q;
      pulse_end    = busy && tick && (cnt_q == cur_len - 10'd1);
      state_d      = state_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      n_d          = n_q;
      status_d     = status_q;
      data_d       = data_q;
      crc_d        = crc_q;
      pause_en_d   = pause_en_q;
      pause_d      = pause_q;
      frame_done_d = pulse_end && ((state_q == ST_CRC && !pause_en_q) || state_q == ST_PAUSE);
      if (accept) begin
         state_d    = ST_SYNC;
         cnt_d      = 10'd0;
         idx_d      = 3'd0;
         n_d        = n_eff;
         status_d   = status_nibble;
         // shift the first (most significant) nibble up to bits [23:20]
         data_d     = data_nibbles << {3'd6 - n_eff, 2'b00};
         crc_d      = crc_nibble;
         pause_en_d = pause_en;
         pause_d    = pause_ticks < 10'(PAUSE_MIN_TICKS) ? 10'(PAUSE_MIN_TICKS) : pause_ticks;
      end else if (busy && tick) begin
         cnt_d = pulse_end ? 10'd0 : cnt_q + 10'd1;
         if (pulse_end) begin
            case (state_q)
               ST_SYNC:   state_d = ST_STATUS;
               ST_STATUS: state_d = ST_DATA;
               ST_DATA: begin
                  data_d  = data_q << 4;
                  idx_d   = idx_q + 3'd1;
                  state_d = idx_q == n_q - 3'd1 ? ST_CRC : ST_DATA;
               end
               ST_CRC:    state_d = pause_en_q ? ST_PAUSE : ST_IDLE;
               default:   state_d = ST_IDLE;
            endcase
         end
      end
      sent_out_d = state_d == ST_IDLE || cnt_d >= 10'(LOW_TICKS);
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 10'd0;
         idx_q        <= 3'd0;
         n_q          <= 3'd0;
         status_q     <= 4'd0;
         data_q       <= 24'd0;
         crc_q        <= 4'd0;
         pause_en_q   <= 1'b0;
         pause_q      <= 10'd0;
         sent_out_q   <= 1'b1;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         n_q          <= n_d;
         status_q     <= status_d;
         data_q       <= data_d;
         crc_q        <= crc_d;
         pause_en_q   <= pause_en_d;
         pause_q      <= pause_d;
         sent_out_q   <= sent_out_d;
         frame_done_q <= frame_done_d;
      end
endmodule

// File: tb/tb_sent_tx_pulse_gen.sv
// tb_sent_tx_pulse_gen: directed self-checking bench for sent_tx_pulse_gen (CLK_PER_TICK 1 and 3).
module tb_sent_tx_pulse_gen;
   logic        clk = 1'b0, reset = 1'b1, fv1 = 1'b0, fv3 = 1'b0, pause_en = 1'b0;
   logic [3:0]  status_nibble = 4'd0, crc_nibble = 4'd0;
   logic [23:0] data_nibbles = 24'd0;
   logic [2:0]  num_nibbles = 3'd1;
   logic [9:0]  pause_ticks = 10'd0;
   logic        fr1, so1, busy1, fd1, fr3, so3, busy3, fd3;
   logic        last_so, last_fr;
   int          tests = 0, fails = 0;
   int          falls[16], lows[16], exp_t[16];
   int          nf, ne, done_cyc;

   always #5 clk = ~clk;

   sent_tx_pulse_gen #(.CLK_PER_TICK(1)) dut1 (
      .clk(clk), .reset(reset), .frame_valid(fv1), .frame_ready(fr1),
      .status_nibble(status_nibble), .data_nibbles(data_nibbles), .num_nibbles(num_nibbles),
      .crc_nibble(crc_nibble), .pause_en(pause_en), .pause_ticks(pause_ticks),
      .sent_out(so1), .busy(busy1), .frame_done(fd1)
   );

   sent_tx_pulse_gen #(.CLK_PER_TICK(3)) dut3 (
      .clk(clk), .reset(reset), .frame_valid(fv3), .frame_ready(fr3),
      .status_nibble(status_nibble), .data_nibbles(data_nibbles), .num_nibbles(num_nibbles),
      .crc_nibble(crc_nibble), .pause_en(pause_en), .pause_ticks(pause_ticks),
      .sent_out(so3), .busy(busy3), .frame_done(fd3)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_frame(input logic [3:0] st, input logic [23:0] d, input logic [2:0] n,
                            input logic [3:0] c, input logic pe, input logic [9:0] pt);
      status_nibble = st; data_nibbles = d; num_nibbles = n;
      crc_nibble = c; pause_en = pe; pause_ticks = pt;
   endtask

   // expected pulse lengths in ticks for the frame currently on the inputs
   task automatic model();
      int n;
      logic [23:0] d;
      d = data_nibbles;
      n = (num_nibbles == 3'd0 || num_nibbles == 3'd7) ? 6 : int'(num_nibbles);
      ne = 0;
      exp_t[ne] = 56; ne++;
      exp_t[ne] = 12 + int'(status_nibble); ne++;
      for (int i = n - 1; i >= 0; i--) begin
         exp_t[ne] = 12 + int'(d[4*i +: 4]); ne++;
      end
      exp_t[ne] = 12 + int'(crc_nibble); ne++;
      if (pause_en) begin
         exp_t[ne] = pause_ticks < 10'd12 ? 12 : int'(pause_ticks); ne++;
      end
   endtask

   task automatic start(input bit sel, input bit hold);
      @(negedge clk);
      if (sel) fv3 = 1'b1; else fv1 = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) begin fv1 = 1'b0; fv3 = 1'b0; end
   endtask

   // records falling edges and low lengths, cycle 1 = first cycle after acceptance
   task automatic capture(input bit sel);
      int  cyc;
      logic prev, so, fd;
      nf = 0; done_cyc = 0; cyc = 0; prev = 1'b1;
      while (done_cyc == 0 && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         so = sel ? so3 : so1;
         fd = sel ? fd3 : fd1;
         if (!so && prev && nf < 16) begin falls[nf] = cyc; lows[nf] = 0; nf++; end
         if (!so && nf > 0) lows[nf-1]++;
         if (fd) done_cyc = cyc;
         prev = so;
      end
      last_so = sel ? so3 : so1;
      last_fr = sel ? fr3 : fr1;
      if (done_cyc == 0) chk("frame_done_timeout", 0, 1);
   endtask

   task automatic verify(input string tag, input int cpt);
      int len, total;
      total = 0;
      chk({tag, ".npulses"}, nf, ne);
      chk({tag, ".latency"}, falls[0], 1);
      for (int k = 0; k < ne && k < nf; k++) begin
         len = (k == nf - 1) ? done_cyc - falls[k] : falls[k+1] - falls[k];
         chk($sformatf("%s.len%0d", tag, k), len, exp_t[k] * cpt);
         chk($sformatf("%s.low%0d", tag, k), lows[k], 4 * cpt);
      end
      for (int k = 0; k < ne; k++) total += exp_t[k];
      chk({tag, ".total"}, done_cyc - 1, total * cpt);
      chk({tag, ".end_high"}, int'(last_so), 1);
   endtask

   initial begin
      int first_done;
      repeat (3) @(negedge clk);
      chk("rst.sent_out", int'(so1), 1);
      chk("rst.frame_ready", int'(fr1), 1);
      chk("rst.busy", int'(busy1), 0);
      chk("rst.frame_done", int'(fd1), 0);
      chk("rst.sent_out3", int'(so3), 1);
      reset = 1'b0;

      set_frame(4'h0, 24'h0002C7, 3'd3, 4'hD, 1'b0, 10'd0);
      model();
      chk("t034.model_sum", exp_t[2] + exp_t[3] + exp_t[4] + exp_t[5], 82);
      start(0, 0);
      chk("t034.busy", int'(busy1), 1);
      chk("t034.ready_busy", int'(fr1), 0);
      capture(0);
      verify("t034", 1);
      chk("t034.ready_at_done", int'(last_fr), 1);
      @(negedge clk);
      chk("t034.done_once", int'(fd1), 0);

      start(1, 0);
      capture(1);
      verify("t035", 3);
      chk("t035.sync_low", lows[0], 12);
      chk("t035.total450", done_cyc - 1, 450);

      set_frame(4'h0, 24'hFFFFFF, 3'd6, 4'h0, 1'b0, 10'd0);
      model();
      start(0, 0);
      capture(0);
      verify("t036a", 1);
      first_done = done_cyc;
      set_frame(4'h0, 24'hFFFFFF, 3'd0, 4'h0, 1'b0, 10'd0);
      start(0, 0);
      capture(0);
      verify("t036b", 1);
      chk("t036.same_len", done_cyc, first_done);

      set_frame(4'h0, 24'h0002C7, 3'd3, 4'hD, 1'b1, 10'd5);
      model();
      start(0, 0);
      capture(0);
      verify("t037a", 1);
      chk("t037a.pause", done_cyc - falls[nf-1], 12);
      set_frame(4'h0, 24'h0002C7, 3'd3, 4'hD, 1'b1, 10'd300);
      model();
      start(0, 0);
      capture(0);
      verify("t037b", 1);
      chk("t037b.pause", done_cyc - falls[nf-1], 300);

      set_frame(4'h0, 24'h0002C7, 3'd3, 4'hD, 1'b0, 10'd0);
      model();
      start(0, 1);
      fork
         begin
            repeat (20) @(negedge clk);
            set_frame(4'h5, 24'hA3A3A3, 3'd2, 4'h1, 1'b0, 10'd0);
         end
      join_none
      capture(0);
      verify("t038a", 1);
      chk("t038.ready_at_done", int'(last_fr), 1);
      model();
      fork
         begin
            @(posedge clk);
            #1 fv1 = 1'b0;
         end
      join_none
      capture(0);
      verify("t038b", 1);
      @(negedge clk);

      set_frame(4'h0, 24'h0002C7, 3'd3, 4'hD, 1'b0, 10'd0);
      model();
      start(0, 0);
      repeat (84) @(negedge clk);
      chk("t039.low_nib2", int'(so1), 0);
      #2 reset = 1'b1;
      #1;
      chk("t039.async_high", int'(so1), 1);
      chk("t039.busy", int'(busy1), 0);
      chk("t039.ready", int'(fr1), 1);
      repeat (3) begin
         @(negedge clk);
         chk("t039.no_done", int'(fd1), 0);
      end
      reset = 1'b0;
      start(0, 0);
      capture(0);
      verify("t039n", 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
